// File: rtl/priority_encoder.sv
// priority_encoder: registered priority encoder.
// Reduces a WIDTH-bit request vector to the index of the winning request,
// along with a valid flag, the isolated one-hot winner and a multi-request flag.
// MSB_FIRST selects whether the highest or the lowest set index wins.
module priority_encoder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned OUT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] i,
    output logic [OUT_W-1:0] out,
    output logic             valid,
    output logic [WIDTH-1:0] onehot,
    output logic             multi
);

    logic [OUT_W-1:0] win_idx;
    logic [WIDTH-1:0] win_hot;
    logic [WIDTH-1:0] probe;
    logic             valid_c;
    logic             multi_c;
    int unsigned      sel;

    // Scan from lowest to highest priority so the last set bit seen is the winner.
    always_comb begin
        win_idx = '0;
        win_hot = '0;
        probe   = '0;
        sel     = 0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            sel   = MSB_FIRST ? k : (WIDTH - 1 - k);
            probe = i >> sel;
            if (probe[0]) begin
                win_idx = OUT_W'(sel);
                win_hot = WIDTH'(1) << sel;
            end
        end
    end

    // Request summary flags; clearing the lowest set bit leaves something only
    // when two or more requests are present, independent of priority order.
    always_comb begin
        valid_c = |i;
        multi_c = |(i & (i - WIDTH'(1)));
    end

    // Output registers: reset dominates, otherwise capture when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out    <= '0;
            valid  <= 1'b0;
            onehot <= '0;
            multi  <= 1'b0;
        end else if (en) begin
            out    <= win_idx;
            valid  <= valid_c;
            onehot <= win_hot;
            multi  <= multi_c;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: self-checking bench for priority_encoder.
// Three instances share control: 8-bit MSB-first, 8-bit LSB-first, 5-bit MSB-first.
// Expected outputs come from the last captured vector via arithmetic reference.
module tb_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] i8;
    logic [4:0] i5;

    logic [2:0] out_m, out_l, out_5;
    logic       valid_m, valid_l, valid_5;
    logic [7:0] onehot_m, onehot_l;
    logic [4:0] onehot_5;
    logic       multi_m, multi_l, multi_5;

    int nvec = 0;
    int nerr = 0;

    // Model state: vector last captured by the DUTs (reset acts like all-zero).
    logic [7:0] cap8 = '0;
    logic [4:0] cap5 = '0;

    priority_encoder #(.WIDTH(8), .OUT_W(3), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i8),
        .out(out_m), .valid(valid_m), .onehot(onehot_m), .multi(multi_m));

    priority_encoder #(.WIDTH(8), .OUT_W(3), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i8),
        .out(out_l), .valid(valid_l), .onehot(onehot_l), .multi(multi_l));

    priority_encoder #(.WIDTH(5), .OUT_W(3), .MSB_FIRST(1'b1)) u_w5 (
        .clk(clk), .rst_n(rst_n), .en(en), .i(i5),
        .out(out_5), .valid(valid_5), .onehot(onehot_5), .multi(multi_5));

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Expected {out, valid, onehot, multi} for an 8-bit vector.
    function automatic logic [12:0] exp8(input logic [7:0] v, input bit msb);
        logic [2:0] o;
        logic [7:0] lo;
        logic [7:0] oh;
        if (v == 8'd0) return '0;
        if (msb) begin
            o = 3'($clog2(int'(v) + 1) - 1);
        end else begin
            lo = v & (~v + 8'd1);
            o  = 3'($clog2(int'(lo)));
        end
        oh = 8'd1 << o;
        return {o, 1'b1, oh, ($countones(v) >= 2)};
    endfunction

    // Expected {out, valid, onehot, multi} for the 5-bit MSB-first instance.
    function automatic logic [9:0] exp5(input logic [4:0] v);
        logic [2:0] o;
        logic [4:0] oh;
        if (v == 5'd0) return '0;
        o  = 3'($clog2(int'(v) + 1) - 1);
        oh = 5'd1 << o;
        return {o, 1'b1, oh, ($countones(v) >= 2)};
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, settle past it.
    task automatic step(input logic r, input logic e, input logic [7:0] v8, input logic [4:0] v5);
        rst_n = r;
        en    = e;
        i8    = v8;
        i5    = v5;
        @(posedge clk);
        if (!r) begin
            cap8 = '0;
            cap5 = '0;
        end else if (e) begin
            cap8 = v8;
            cap5 = v5;
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, 8'hFF, 5'h1F);
        nvec++;
        if ({out_m, valid_m, onehot_m, multi_m} !== 13'd0) begin
            nerr++;
            $display("FAIL reset_msb got=%h want=0", {out_m, valid_m, onehot_m, multi_m});
        end
        nvec++;
        if ({out_l, valid_l, onehot_l, multi_l} !== 13'd0) begin
            nerr++;
            $display("FAIL reset_lsb got=%h want=0", {out_l, valid_l, onehot_l, multi_l});
        end
        nvec++;
        if ({out_5, valid_5, onehot_5, multi_5} !== 10'd0) begin
            nerr++;
            $display("FAIL reset_w5 got=%h want=0", {out_5, valid_5, onehot_5, multi_5});
        end
    endtask

    task automatic test_walking;
        logic [7:0] v;
        for (int n = 7; n >= 0; n--) begin
            v = 8'd1 << n;
            step(1'b1, 1'b1, v, 5'd0);
            nvec++;
            if (out_m !== 3'(n) || valid_m !== 1'b1 || multi_m !== 1'b0 || onehot_m !== v) begin
                nerr++;
                $display("FAIL walk_msb n=%0d got out=%0d v=%b oh=%h m=%b want out=%0d v=1 oh=%h m=0",
                         n, out_m, valid_m, onehot_m, multi_m, n, v);
            end
            nvec++;
            if ({out_l, valid_l, onehot_l, multi_l} !== exp8(v, 1'b0)) begin
                nerr++;
                $display("FAIL walk_lsb n=%0d got=%h want=%h", n, {out_l, valid_l, onehot_l, multi_l}, exp8(v, 1'b0));
            end
        end
    endtask

    task automatic test_multi;
        step(1'b1, 1'b1, 8'b1010_0110, 5'b1_0110);
        nvec++;
        if (out_m !== 3'd7 || onehot_m !== 8'h80 || multi_m !== 1'b1 || valid_m !== 1'b1) begin
            nerr++;
            $display("FAIL multi_msb got out=%0d oh=%h m=%b v=%b want out=7 oh=80 m=1 v=1",
                     out_m, onehot_m, multi_m, valid_m);
        end
        nvec++;
        if (out_l !== 3'd1 || onehot_l !== 8'h02 || multi_l !== 1'b1 || valid_l !== 1'b1) begin
            nerr++;
            $display("FAIL multi_lsb got out=%0d oh=%h m=%b v=%b want out=1 oh=02 m=1 v=1",
                     out_l, onehot_l, multi_l, valid_l);
        end
        nvec++;
        if (out_5 !== 3'd4 || onehot_5 !== 5'h10 || multi_5 !== 1'b1) begin
            nerr++;
            $display("FAIL multi_w5 got out=%0d oh=%h m=%b want out=4 oh=10 m=1", out_5, onehot_5, multi_5);
        end
    endtask

    task automatic test_empty;
        step(1'b1, 1'b1, 8'h00, 5'h00);
        nvec++;
        if ({out_m, valid_m, onehot_m, multi_m} !== 13'd0) begin
            nerr++;
            $display("FAIL empty_msb got=%h want=0", {out_m, valid_m, onehot_m, multi_m});
        end
        nvec++;
        if ({out_l, valid_l, onehot_l, multi_l} !== 13'd0) begin
            nerr++;
            $display("FAIL empty_lsb got=%h want=0", {out_l, valid_l, onehot_l, multi_l});
        end
        step(1'b1, 1'b1, 8'h01, 5'h01);
        nvec++;
        if (out_m !== 3'd0 || valid_m !== 1'b1 || onehot_m !== 8'h01 || multi_m !== 1'b0) begin
            nerr++;
            $display("FAIL bit0_msb got out=%0d v=%b oh=%h m=%b want out=0 v=1 oh=01 m=0",
                     out_m, valid_m, onehot_m, multi_m);
        end
    endtask

    task automatic test_enable_hold;
        step(1'b1, 1'b1, 8'h10, 5'h04);
        nvec++;
        if (out_m !== 3'd4) begin
            nerr++;
            $display("FAIL hold_capture got out=%0d want 4", out_m);
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0, 8'h80, 5'h10);
            nvec++;
            if (out_m !== 3'd4 || onehot_m !== 8'h10 || valid_m !== 1'b1 || out_5 !== 3'd2) begin
                nerr++;
                $display("FAIL hold_cycle%0d got out=%0d oh=%h v=%b out5=%0d want out=4 oh=10 v=1 out5=2",
                         c, out_m, onehot_m, valid_m, out_5);
            end
        end
        step(1'b1, 1'b1, 8'h80, 5'h10);
        nvec++;
        if (out_m !== 3'd7 || out_5 !== 3'd4) begin
            nerr++;
            $display("FAIL hold_release got out=%0d out5=%0d want out=7 out5=4", out_m, out_5);
        end
    endtask

    task automatic test_reset_glitch;
        step(1'b1, 1'b1, 8'h80, 5'h10);
        // Short rst_n pulse entirely between two rising edges.
        en    = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h01, 5'h01);
        nvec++;
        if (out_m !== 3'd7 || valid_m !== 1'b1 || onehot_m !== 8'h80) begin
            nerr++;
            $display("FAIL glitch_ignored got out=%0d v=%b oh=%h want out=7 v=1 oh=80", out_m, valid_m, onehot_m);
        end
        step(1'b0, 1'b1, 8'hFF, 5'h1F);
        nvec++;
        if ({out_m, valid_m, onehot_m, multi_m} !== 13'd0 || {out_5, valid_5, onehot_5, multi_5} !== 10'd0) begin
            nerr++;
            $display("FAIL reset_over_en got msb=%h w5=%h want 0", {out_m, valid_m, onehot_m, multi_m},
                     {out_5, valid_5, onehot_5, multi_5});
        end
        // The vector presented during reset is discarded, not replayed.
        step(1'b1, 1'b0, 8'h00, 5'h00);
        nvec++;
        if (valid_m !== 1'b0 || out_m !== 3'd0) begin
            nerr++;
            $display("FAIL reset_discard got out=%0d v=%b want out=0 v=0", out_m, valid_m);
        end
    endtask

    task automatic test_random;
        logic r, e;
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 19) != 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, 8'($urandom), 5'($urandom));
            nvec++;
            if ({out_m, valid_m, onehot_m, multi_m} !== exp8(cap8, 1'b1)) begin
                nerr++;
                $display("FAIL rand_msb n=%0d cap=%h got=%h want=%h", n, cap8,
                         {out_m, valid_m, onehot_m, multi_m}, exp8(cap8, 1'b1));
            end
            nvec++;
            if ({out_l, valid_l, onehot_l, multi_l} !== exp8(cap8, 1'b0)) begin
                nerr++;
                $display("FAIL rand_lsb n=%0d cap=%h got=%h want=%h", n, cap8,
                         {out_l, valid_l, onehot_l, multi_l}, exp8(cap8, 1'b0));
            end
            nvec++;
            if ({out_5, valid_5, onehot_5, multi_5} !== exp5(cap5)) begin
                nerr++;
                $display("FAIL rand_w5 n=%0d cap=%h got=%h want=%h", n, cap5,
                         {out_5, valid_5, onehot_5, multi_5}, exp5(cap5));
            end
        end
    endtask

    task automatic test_width5_sweep;
        for (int v = 0; v < 32; v++) begin
            step(1'b1, 1'b1, 8'(v), 5'(v));
            nvec++;
            if ({out_5, valid_5, onehot_5, multi_5} !== exp5(5'(v)) || out_5 >= 3'd5) begin
                nerr++;
                $display("FAIL sweep_w5 i=%0d got out=%0d v=%b oh=%b m=%b want=%h", v, out_5, valid_5,
                         onehot_5, multi_5, exp5(5'(v)));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        i8    = '0;
        i5    = '0;
        test_reset();
        test_walking();
        test_multi();
        test_empty();
        test_enable_hold();
        test_reset_glitch();
        test_width5_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- Registered, parameterizable priority encoder.
- Converts a WIDTH-bit request vector into the binary index of the winning (highest-priority) set bit, plus a valid flag, the isolated one-hot winner and a multiple-request flag.
- Used wherever a bank of request/flag lines must be reduced to a single index, e.g. arbitration front-ends and interrupt/status decoding.
- Default configuration is 8 inputs to a 3-bit index, MSB has highest priority.

Parameters:
- WIDTH, 8, number of request inputs; legal range 2..64.
- OUT_W, $clog2(WIDTH), width of the index output; must be at least 1.
- MSB_FIRST, 1, 1 = highest index wins; 0 = lowest index wins.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  capture enable; outputs update only when high.
- i  input  WIDTH  request vector; bit k set = request k.
- out  output  OUT_W  binary index of winning request.
- valid  output  1  at least one request was set in the captured vector.
- onehot  output  WIDTH  captured vector with only the winning bit kept.
- multi  output  1  two or more requests were set in the captured vector.

Behaviour:
- All outputs are registered. Each is driven directly from a flop, with no combinational path from i to any output.
- Reset: on a rising clk edge with rst_n = 0, out = 0, valid = 0, onehot = 0 and multi = 0. Reset has priority over en.
- Reset is synchronous: an rst_n low pulse that does not span a rising edge has no effect.
- Latency: with rst_n = 1 and en = 1, the vector i sampled at edge N is reflected on all outputs immediately after edge N. That is one cycle of latency, and full throughput of one vector per cycle.
- With en = 0 (and rst_n = 1), all outputs hold their previous values.
- Winner selection, MSB_FIRST = 1: out = the largest k with i[k] = 1.
- Winner selection, MSB_FIRST = 0: out = the smallest k with i[k] = 1.
- onehot = 1 << out when valid, else 0.
- valid = OR-reduction of i.
- multi = 1 iff the population count of i is 2 or more. It must not depend on the winner.
- All-zero input: valid = 0, out = 0, onehot = 0, multi = 0. Downstream must qualify out with valid, because out = 0 with valid = 1 means request 0 won.
- Lower-priority bits are don't-care for out and onehot; only the winner matters.
- Non-power-of-two WIDTH: index values at or above WIDTH are never produced.
- Input containing X/Z is not supported. There is no defined output for it.
- Reset asserted in the same cycle as en = 1 with a nonzero i: the outputs take the reset values. The sampled vector is discarded, not deferred.
- Synthesizable; the selection logic must be a loop or tree scaling with WIDTH, not a hard-coded 8-way case.

Test Plan:
- Walking one, default parameters, en = 1: apply i = 128, 64, 32, 16, 8, 4, 2, 1 on consecutive cycles -> out = 7, 6, 5, 4, 3, 2, 1, 0 one cycle later each; valid = 1 and multi = 0 throughout; onehot equals the applied i.
- Multiple requests: i = 8'b1010_0110 -> out = 7, onehot = 8'h80, multi = 1, valid = 1. With MSB_FIRST = 0 the same input -> out = 1, onehot = 8'h02, multi = 1.
- Empty input: i = 8'h00 after a nonzero vector -> next cycle valid = 0, out = 0, onehot = 0, multi = 0. Then i = 8'h01 -> out = 0, valid = 1.
- Enable hold: capture i = 8'h10 (out = 4), then drive en = 0 and change i to 8'h80 for 3 cycles -> out stays 4. Re-assert en -> out = 7 one cycle later.
- Reset: with outputs showing out = 7, valid = 1, hold rst_n = 0 for one edge with en = 1 and i = 8'hFF -> all outputs 0 after that edge. A glitch on rst_n between edges changes nothing.
- Parameter sweep: WIDTH = 5, OUT_W = 3, MSB_FIRST = 1, exhaustive i = 0..31 -> out and multi match a reference model; out is never 5, 6 or 7.
